// File: rtl/bus_spi_iq_arbiter_pkg.sv
// Shared constants for the RX1/RX2 IQ arbiter in front of the BUS SPI master:
// FSM state encodings, channel and word identifiers, and the tag encoding.
package bus_spi_pkg;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_SEND    = 3'd1;
    localparam logic [2:0] ST_WAIT_LO = 3'd2;
    localparam logic [2:0] ST_GAP     = 3'd3;
    localparam logic [2:0] ST_DONE    = 3'd4;

    localparam logic CH_RX1 = 1'b0;
    localparam logic CH_RX2 = 1'b1;

    localparam logic WORD_I = 1'b0;
    localparam logic WORD_Q = 1'b1;

    // Tag seen by the SPI side: channel in the upper bit, word select in the lower bit.
    function automatic logic [1:0] make_tag(input logic ch, input logic word);
        return {ch, word};
    endfunction

endpackage

// File: rtl/bus_spi_iq_arbiter_iq_hold_slot.sv
// One-deep holding slot for a single IQ channel: keeps the newest I/Q pair,
// a pending flag for the arbiter and a saturating overrun counter.
module iq_hold_slot #(
    parameter int DATA_WIDTH = 32,
    parameter int OVR_W      = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  valid,
    input  logic [DATA_WIDTH-1:0] i_in,
    input  logic [DATA_WIDTH-1:0] q_in,
    input  logic                  grant,
    input  logic                  clear_ovr,
    output logic                  pending,
    output logic [DATA_WIDTH-1:0] i_hold,
    output logic [DATA_WIDTH-1:0] q_hold,
    output logic [OVR_W-1:0]      ovr
);

    logic capture;
    logic overrun;

    assign capture = en & valid;
    // A pair that is being granted this cycle leaves the slot, so a new pair
    // arriving alongside the grant does not overwrite anything.
    assign overrun = capture & pending & ~grant;

    // Slot contents, pending flag and overrun counter (increment beats clear).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending <= 1'b0;
            i_hold  <= '0;
            q_hold  <= '0;
            ovr     <= '0;
        end else begin
            if (!en)
                pending <= 1'b0;
            else if (valid)
                pending <= 1'b1;
            else if (grant)
                pending <= 1'b0;

            if (capture) begin
                i_hold <= i_in;
                q_hold <= q_in;
            end

            if (overrun) begin
                if (!(&ovr))
                    ovr <= ovr + 1'b1;
            end else if (clear_ovr) begin
                ovr <= '0;
            end
        end
    end

endmodule

// File: rtl/bus_spi_iq_arbiter.sv
// Shares the single BUS SPI master between RX1 and RX2 IQ streams: two hold
// slots, a 2-way round-robin, and a word-level enable/busy handshake FSM with
// a timeout that discards a stuck pair.
module bus_spi_iq_arbiter
    import bus_spi_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255,
    parameter int OVR_W          = 8
) (
    input  logic                  spi_clk,
    input  logic                  reset_n,
    input  logic                  rx1_en,
    input  logic                  rx2_en,
    input  logic [DATA_WIDTH-1:0] RX1_I,
    input  logic [DATA_WIDTH-1:0] RX1_Q,
    input  logic                  RX1_valid,
    input  logic [DATA_WIDTH-1:0] RX2_I,
    input  logic [DATA_WIDTH-1:0] RX2_Q,
    input  logic                  RX2_valid,
    input  logic                  BUS_SPI_busy,
    input  logic                  clear_err,
    output logic [DATA_WIDTH-1:0] BUS_SPI_data_out,
    output logic                  BUS_SPI_enable,
    output logic [1:0]            BUS_SPI_tag,
    output logic                  pair_done,
    output logic [OVR_W-1:0]      rx1_ovr,
    output logic [OVR_W-1:0]      rx2_ovr,
    output logic                  timeout_err
);

    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    // Per-channel slot wiring, index 0 = RX1, index 1 = RX2.
    logic [1:0]            slot_en;
    logic [1:0]            slot_valid;
    logic [1:0]            slot_grant;
    logic [1:0]            slot_pending;
    logic [DATA_WIDTH-1:0] slot_i_in   [2];
    logic [DATA_WIDTH-1:0] slot_q_in   [2];
    logic [DATA_WIDTH-1:0] slot_i_hold [2];
    logic [DATA_WIDTH-1:0] slot_q_hold [2];
    logic [OVR_W-1:0]      slot_ovr    [2];

    assign slot_en      = {rx2_en, rx1_en};
    assign slot_valid   = {RX2_valid, RX1_valid};
    assign slot_i_in[0] = RX1_I;
    assign slot_q_in[0] = RX1_Q;
    assign slot_i_in[1] = RX2_I;
    assign slot_q_in[1] = RX2_Q;
    assign rx1_ovr      = slot_ovr[0];
    assign rx2_ovr      = slot_ovr[1];

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_slot
            iq_hold_slot #(
                .DATA_WIDTH (DATA_WIDTH),
                .OVR_W      (OVR_W)
            ) u_slot (
                .clk       (spi_clk),
                .rst_n     (reset_n),
                .en        (slot_en[gi]),
                .valid     (slot_valid[gi]),
                .i_in      (slot_i_in[gi]),
                .q_in      (slot_q_in[gi]),
                .grant     (slot_grant[gi]),
                .clear_ovr (clear_err),
                .pending   (slot_pending[gi]),
                .i_hold    (slot_i_hold[gi]),
                .q_hold    (slot_q_hold[gi]),
                .ovr       (slot_ovr[gi])
            );
        end
    endgenerate

    logic [2:0]            state_reg;
    logic                  ch_reg;
    logic                  word_reg;
    logic                  last_grant_reg;
    logic [DATA_WIDTH-1:0] xfer_q_reg;
    logic [TMO_W-1:0]      tmo_cnt_reg;

    logic grant_valid;
    logic grant_ch;
    logic tmo_abort;

    // Round-robin choice, only evaluated while the FSM is idle.
    always_comb begin
        grant_valid = 1'b0;
        grant_ch    = CH_RX1;
        if (state_reg == ST_IDLE) begin
            if (slot_pending[0] && slot_pending[1]) begin
                grant_valid = 1'b1;
                grant_ch    = ~last_grant_reg;
            end else if (slot_pending[0]) begin
                grant_valid = 1'b1;
                grant_ch    = CH_RX1;
            end else if (slot_pending[1]) begin
                grant_valid = 1'b1;
                grant_ch    = CH_RX2;
            end
        end
    end

    assign slot_grant[0] = grant_valid & (grant_ch == CH_RX1);
    assign slot_grant[1] = grant_valid & (grant_ch == CH_RX2);

    // Abort when the handshake edge being waited for has not arrived in time.
    assign tmo_abort = (tmo_cnt_reg == TMO_LAST) &&
                       (((state_reg == ST_SEND) && !BUS_SPI_busy) ||
                        ((state_reg == ST_WAIT_LO) && BUS_SPI_busy));

    // Transfer FSM, handshake outputs, timeout counter and sticky error.
    always_ff @(posedge spi_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg        <= ST_IDLE;
            ch_reg           <= CH_RX1;
            word_reg         <= WORD_I;
            last_grant_reg   <= CH_RX2;
            xfer_q_reg       <= '0;
            tmo_cnt_reg      <= '0;
            BUS_SPI_data_out <= '0;
            BUS_SPI_enable   <= 1'b0;
            BUS_SPI_tag      <= 2'b00;
            pair_done        <= 1'b0;
            timeout_err      <= 1'b0;
        end else begin
            pair_done <= 1'b0;

            if (tmo_abort)
                timeout_err <= 1'b1;
            else if (clear_err)
                timeout_err <= 1'b0;

            case (state_reg)
                ST_IDLE: begin
                    if (grant_valid) begin
                        state_reg        <= ST_SEND;
                        ch_reg           <= grant_ch;
                        word_reg         <= WORD_I;
                        last_grant_reg   <= grant_ch;
                        xfer_q_reg       <= slot_q_hold[grant_ch];
                        BUS_SPI_data_out <= slot_i_hold[grant_ch];
                        BUS_SPI_tag      <= make_tag(grant_ch, WORD_I);
                        BUS_SPI_enable   <= 1'b1;
                        tmo_cnt_reg      <= '0;
                    end
                end
                ST_SEND: begin
                    if (BUS_SPI_busy) begin
                        state_reg   <= ST_WAIT_LO;
                        tmo_cnt_reg <= '0;
                    end else if (tmo_abort) begin
                        state_reg      <= ST_IDLE;
                        BUS_SPI_enable <= 1'b0;
                    end else begin
                        tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
                    end
                end
                ST_WAIT_LO: begin
                    if (!BUS_SPI_busy) begin
                        BUS_SPI_enable <= 1'b0;
                        if (word_reg == WORD_I) begin
                            state_reg <= ST_GAP;
                        end else begin
                            state_reg <= ST_DONE;
                            pair_done <= 1'b1;
                        end
                    end else if (tmo_abort) begin
                        state_reg      <= ST_IDLE;
                        BUS_SPI_enable <= 1'b0;
                    end else begin
                        tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
                    end
                end
                ST_GAP: begin
                    state_reg        <= ST_SEND;
                    word_reg         <= WORD_Q;
                    BUS_SPI_data_out <= xfer_q_reg;
                    BUS_SPI_tag      <= make_tag(ch_reg, WORD_Q);
                    BUS_SPI_enable   <= 1'b1;
                    tmo_cnt_reg      <= '0;
                end
                ST_DONE: begin
                    state_reg <= ST_IDLE;
                end
                default: begin
                    state_reg      <= ST_IDLE;
                    BUS_SPI_enable <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bus_spi_iq_arbiter.sv
// Bench for bus_spi_iq_arbiter: a behavioural SPI master answers each enable
// with busy after one cycle for eight cycles and logs the word it accepted;
// expected words are queued as stimulus is driven and compared in order.
module tb_bus_spi_iq_arbiter;

    logic        spi_clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        rx1_en = 1'b1;
    logic        rx2_en = 1'b1;
    logic [31:0] RX1_I = '0, RX1_Q = '0, RX2_I = '0, RX2_Q = '0;
    logic        RX1_valid = 1'b0, RX2_valid = 1'b0;
    logic        BUS_SPI_busy;
    logic        clear_err = 1'b0;
    logic [31:0] BUS_SPI_data_out;
    logic        BUS_SPI_enable;
    logic [1:0]  BUS_SPI_tag;
    logic        pair_done;
    logic [7:0]  rx1_ovr, rx2_ovr;
    logic        timeout_err;

    int n_checks = 0;
    int n_pass   = 0;

    logic [33:0] exp_q[$];
    logic [33:0] obs_q[$];

    bit busy_en = 1'b1;
    int m_state = 0;
    int m_cnt   = 0;
    int pd_count = 0;

    bus_spi_iq_arbiter #(
        .DATA_WIDTH     (32),
        .TIMEOUT_CYCLES (16),
        .OVR_W          (8)
    ) dut (
        .spi_clk          (spi_clk),
        .reset_n          (reset_n),
        .rx1_en           (rx1_en),
        .rx2_en           (rx2_en),
        .RX1_I            (RX1_I),
        .RX1_Q            (RX1_Q),
        .RX1_valid        (RX1_valid),
        .RX2_I            (RX2_I),
        .RX2_Q            (RX2_Q),
        .RX2_valid        (RX2_valid),
        .BUS_SPI_busy     (BUS_SPI_busy),
        .clear_err        (clear_err),
        .BUS_SPI_data_out (BUS_SPI_data_out),
        .BUS_SPI_enable   (BUS_SPI_enable),
        .BUS_SPI_tag      (BUS_SPI_tag),
        .pair_done        (pair_done),
        .rx1_ovr          (rx1_ovr),
        .rx2_ovr          (rx2_ovr),
        .timeout_err      (timeout_err)
    );

    always #5 spi_clk = ~spi_clk;

    // SPI master model: 1 cycle from enable to busy, busy high for 8 cycles.
    always @(negedge spi_clk) begin
        if (!reset_n) begin
            BUS_SPI_busy <= 1'b0;
            m_state      <= 0;
            m_cnt        <= 0;
        end else begin
            case (m_state)
                0: if (BUS_SPI_enable && busy_en) m_state <= 1;
                1: begin
                    BUS_SPI_busy <= 1'b1;
                    m_cnt        <= 8;
                    m_state      <= 2;
                    obs_q.push_back({BUS_SPI_tag, BUS_SPI_data_out});
                    $display("spi word tag=%b data=%h", BUS_SPI_tag, BUS_SPI_data_out);
                end
                2: begin
                    if (m_cnt == 1) begin
                        BUS_SPI_busy <= 1'b0;
                        m_state      <= 3;
                    end else begin
                        m_cnt <= m_cnt - 1;
                    end
                end
                default: if (!BUS_SPI_enable) m_state <= 0;
            endcase
        end
    end

    always @(negedge spi_clk) begin
        if (pair_done) pd_count <= pd_count + 1;
    end

    task automatic wait_cycles(input int n);
        for (int k = 0; k < n; k++) @(negedge spi_clk);
    endtask

    task automatic wait_obs(input int n, input int budget, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < budget; k++) begin
            if (obs_q.size() >= n) begin
                ok = 1'b1;
                break;
            end
            @(negedge spi_clk);
        end
    endtask

    task automatic drive_valid(input logic v1, input logic [31:0] i1, input logic [31:0] q1,
                               input logic v2, input logic [31:0] i2, input logic [31:0] q2);
        @(negedge spi_clk);
        RX1_valid = v1; RX1_I = i1; RX1_Q = q1;
        RX2_valid = v2; RX2_I = i2; RX2_Q = q2;
        @(negedge spi_clk);
        RX1_valid = 1'b0;
        RX2_valid = 1'b0;
    endtask

    task automatic pulse_clear();
        @(negedge spi_clk);
        clear_err = 1'b1;
        @(negedge spi_clk);
        clear_err = 1'b0;
        @(negedge spi_clk);
    endtask

    task automatic apply_reset();
        reset_n = 1'b0;
        wait_cycles(3);
        reset_n = 1'b1;
        wait_cycles(2);
    endtask

    task automatic test_reset();
        apply_reset();
        n_checks += 6;
        if (BUS_SPI_enable !== 1'b0) $display("FAIL reset_enable got=%b want=0", BUS_SPI_enable); else n_pass++;
        if (BUS_SPI_data_out !== 32'h0) $display("FAIL reset_data got=%h want=0", BUS_SPI_data_out); else n_pass++;
        if (BUS_SPI_tag !== 2'b00) $display("FAIL reset_tag got=%b want=00", BUS_SPI_tag); else n_pass++;
        if (pair_done !== 1'b0) $display("FAIL reset_pair_done got=%b want=0", pair_done); else n_pass++;
        if ({rx1_ovr, rx2_ovr} !== 16'h0) $display("FAIL reset_ovr got=%h want=0", {rx1_ovr, rx2_ovr}); else n_pass++;
        if (timeout_err !== 1'b0) $display("FAIL reset_timeout_err got=%b want=0", timeout_err); else n_pass++;
    endtask

    task automatic test_single_pair();
        bit ok;
        int pd0;
        logic [33:0] e, o;
        pd0 = pd_count;
        exp_q.push_back({2'b00, 32'h12345678});
        exp_q.push_back({2'b01, 32'h9ABCDEF0});
        drive_valid(1'b1, 32'h12345678, 32'h9ABCDEF0, 1'b0, 32'h0, 32'h0);
        wait_obs(2, 200, ok);
        n_checks++;
        if (!ok) $display("FAIL single_timeout got=%0d words want=2", obs_q.size()); else n_pass++;
        wait_cycles(20);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = (obs_q.size() > 0) ? obs_q.pop_front() : 34'bx;
            n_checks++;
            if (o !== e) $display("FAIL single_word got=%h want=%h", o, e); else n_pass++;
        end
        n_checks += 2;
        if (obs_q.size() != 0) $display("FAIL single_extra got=%0d want=0", obs_q.size()); else n_pass++;
        if (pd_count - pd0 != 1) $display("FAIL single_pair_done got=%0d want=1", pd_count - pd0); else n_pass++;
    endtask

    task automatic test_round_robin();
        bit ok;
        logic [33:0] e, o;
        apply_reset();
        exp_q.push_back({2'b00, 32'hA1A1_0001});
        exp_q.push_back({2'b01, 32'hA1A1_0002});
        drive_valid(1'b1, 32'hA1A1_0001, 32'hA1A1_0002, 1'b1, 32'hA2A2_0001, 32'hA2A2_0002);
        wait_obs(1, 100, ok);
        // RX1 in flight: RX1 slot refills, RX2 pair is overwritten; RX2 won last tie-break loss.
        exp_q.push_back({2'b10, 32'hB2B2_0001});
        exp_q.push_back({2'b11, 32'hB2B2_0002});
        exp_q.push_back({2'b00, 32'hB1B1_0001});
        exp_q.push_back({2'b01, 32'hB1B1_0002});
        drive_valid(1'b1, 32'hB1B1_0001, 32'hB1B1_0002, 1'b1, 32'hB2B2_0001, 32'hB2B2_0002);
        n_checks += 2;
        if (rx2_ovr !== 8'd1) $display("FAIL rr_rx2_ovr got=%0d want=1", rx2_ovr); else n_pass++;
        if (rx1_ovr !== 8'd0) $display("FAIL rr_rx1_ovr got=%0d want=0", rx1_ovr); else n_pass++;
        wait_obs(6, 400, ok);
        n_checks++;
        if (!ok) $display("FAIL rr_timeout got=%0d words want=6", obs_q.size()); else n_pass++;
        wait_cycles(20);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = (obs_q.size() > 0) ? obs_q.pop_front() : 34'bx;
            n_checks++;
            if (o !== e) $display("FAIL rr_word got=%h want=%h", o, e); else n_pass++;
        end
        n_checks++;
        if (obs_q.size() != 0) $display("FAIL rr_extra got=%0d want=0", obs_q.size()); else n_pass++;
        pulse_clear();
        n_checks++;
        if (rx2_ovr !== 8'd0) $display("FAIL rr_clear got=%0d want=0", rx2_ovr); else n_pass++;
    endtask

    task automatic test_overrun();
        bit ok;
        logic [33:0] e, o;
        exp_q.push_back({2'b00, 32'hC1C1_0001});
        exp_q.push_back({2'b01, 32'hC1C1_0002});
        drive_valid(1'b1, 32'hC1C1_0001, 32'hC1C1_0002, 1'b0, 32'h0, 32'h0);
        wait_obs(1, 100, ok);
        for (int k = 1; k <= 3; k++) begin
            drive_valid(1'b0, 32'h0, 32'h0, 1'b1, 32'hD2D2_0000 + k, 32'hE2E2_0000 + k);
        end
        exp_q.push_back({2'b10, 32'hD2D2_0003});
        exp_q.push_back({2'b11, 32'hE2E2_0003});
        n_checks++;
        if (rx2_ovr !== 8'd2) $display("FAIL ovr_count got=%0d want=2", rx2_ovr); else n_pass++;
        wait_obs(4, 300, ok);
        n_checks++;
        if (!ok) $display("FAIL ovr_timeout got=%0d words want=4", obs_q.size()); else n_pass++;
        wait_cycles(20);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = (obs_q.size() > 0) ? obs_q.pop_front() : 34'bx;
            n_checks++;
            if (o !== e) $display("FAIL ovr_word got=%h want=%h", o, e); else n_pass++;
        end
        n_checks++;
        if (obs_q.size() != 0) $display("FAIL ovr_extra got=%0d want=0", obs_q.size()); else n_pass++;
        pulse_clear();
        n_checks++;
        if (rx2_ovr !== 8'd0) $display("FAIL ovr_clear got=%0d want=0", rx2_ovr); else n_pass++;
    endtask

    task automatic test_timeout();
        bit ok;
        int pd0, hi;
        logic [33:0] e, o;
        pd0 = pd_count;
        busy_en = 1'b0;
        drive_valid(1'b1, 32'hDEAD_0001, 32'hDEAD_0002, 1'b0, 32'h0, 32'h0);
        for (int k = 0; k < 20 && !BUS_SPI_enable; k++) @(negedge spi_clk);
        hi = 0;
        while (BUS_SPI_enable && hi < 100) begin
            hi++;
            if (hi == 3) begin
                RX2_valid = 1'b1; RX2_I = 32'hF2F2_0001; RX2_Q = 32'hF2F2_0002;
            end else begin
                RX2_valid = 1'b0;
            end
            @(negedge spi_clk);
        end
        RX2_valid = 1'b0;
        busy_en = 1'b1;
        n_checks += 2;
        if (hi != 16) $display("FAIL tmo_enable_cycles got=%0d want=16", hi); else n_pass++;
        if (timeout_err !== 1'b1) $display("FAIL tmo_err_set got=%b want=1", timeout_err); else n_pass++;
        exp_q.push_back({2'b10, 32'hF2F2_0001});
        exp_q.push_back({2'b11, 32'hF2F2_0002});
        wait_obs(2, 200, ok);
        n_checks++;
        if (!ok) $display("FAIL tmo_next_timeout got=%0d words want=2", obs_q.size()); else n_pass++;
        wait_cycles(20);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = (obs_q.size() > 0) ? obs_q.pop_front() : 34'bx;
            n_checks++;
            if (o !== e) $display("FAIL tmo_word got=%h want=%h", o, e); else n_pass++;
        end
        n_checks += 2;
        if (obs_q.size() != 0) $display("FAIL tmo_extra got=%0d want=0", obs_q.size()); else n_pass++;
        if (pd_count - pd0 != 1) $display("FAIL tmo_pair_done got=%0d want=1", pd_count - pd0); else n_pass++;
        pulse_clear();
        n_checks++;
        if (timeout_err !== 1'b0) $display("FAIL tmo_err_clear got=%b want=0", timeout_err); else n_pass++;
    endtask

    task automatic test_enable();
        bit ok;
        logic [33:0] e, o;
        exp_q.push_back({2'b00, 32'h5151_0001});
        exp_q.push_back({2'b01, 32'h5151_0002});
        drive_valid(1'b1, 32'h5151_0001, 32'h5151_0002, 1'b0, 32'h0, 32'h0);
        wait_obs(1, 100, ok);
        drive_valid(1'b0, 32'h0, 32'h0, 1'b1, 32'h5252_0001, 32'h5252_0002);
        rx2_en = 1'b0;
        wait_cycles(2);
        drive_valid(1'b0, 32'h0, 32'h0, 1'b1, 32'h5353_0001, 32'h5353_0002);
        drive_valid(1'b0, 32'h0, 32'h0, 1'b1, 32'h5454_0001, 32'h5454_0002);
        n_checks++;
        if (rx2_ovr !== 8'd0) $display("FAIL en_ovr got=%0d want=0", rx2_ovr); else n_pass++;
        rx2_en = 1'b1;
        wait_obs(2, 200, ok);
        n_checks++;
        if (!ok) $display("FAIL en_timeout got=%0d words want=2", obs_q.size()); else n_pass++;
        wait_cycles(60);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = (obs_q.size() > 0) ? obs_q.pop_front() : 34'bx;
            n_checks++;
            if (o !== e) $display("FAIL en_word got=%h want=%h", o, e); else n_pass++;
        end
        n_checks++;
        if (obs_q.size() != 0) $display("FAIL en_flushed got=%0d extra words want=0", obs_q.size()); else n_pass++;
    endtask

    task automatic test_async_reset();
        bit ok;
        int pd0;
        logic [33:0] e, o;
        pd0 = pd_count;
        exp_q.push_back({2'b00, 32'h6161_0001});
        exp_q.push_back({2'b01, 32'h6161_0002});
        drive_valid(1'b1, 32'h6161_0001, 32'h6161_0002, 1'b0, 32'h0, 32'h0);
        drive_valid(1'b0, 32'h0, 32'h0, 1'b1, 32'h6262_0001, 32'h6262_0002);
        drive_valid(1'b0, 32'h0, 32'h0, 1'b1, 32'h6363_0001, 32'h6363_0002);
        n_checks++;
        if (rx2_ovr !== 8'd1) $display("FAIL arst_pre_ovr got=%0d want=1", rx2_ovr); else n_pass++;
        wait_obs(2, 200, ok);
        #3;
        reset_n = 1'b0;
        #1;
        n_checks += 4;
        if (BUS_SPI_enable !== 1'b0) $display("FAIL arst_enable got=%b want=0", BUS_SPI_enable); else n_pass++;
        if (rx2_ovr !== 8'd0) $display("FAIL arst_ovr got=%0d want=0", rx2_ovr); else n_pass++;
        if (BUS_SPI_tag !== 2'b00) $display("FAIL arst_tag got=%b want=00", BUS_SPI_tag); else n_pass++;
        if (!ok) $display("FAIL arst_q_word_timeout got=%0d words want=2", obs_q.size()); else n_pass++;
        wait_cycles(3);
        reset_n = 1'b1;
        wait_cycles(2);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = (obs_q.size() > 0) ? obs_q.pop_front() : 34'bx;
            n_checks++;
            if (o !== e) $display("FAIL arst_word got=%h want=%h", o, e); else n_pass++;
        end
        n_checks++;
        if (pd_count != pd0) $display("FAIL arst_no_pair_done got=%0d want=0", pd_count - pd0); else n_pass++;
        exp_q.push_back({2'b00, 32'h7171_0001});
        exp_q.push_back({2'b01, 32'h7171_0002});
        drive_valid(1'b1, 32'h7171_0001, 32'h7171_0002, 1'b0, 32'h0, 32'h0);
        wait_obs(2, 200, ok);
        n_checks++;
        if (!ok) $display("FAIL arst_fresh_timeout got=%0d words want=2", obs_q.size()); else n_pass++;
        wait_cycles(20);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = (obs_q.size() > 0) ? obs_q.pop_front() : 34'bx;
            n_checks++;
            if (o !== e) $display("FAIL arst_fresh_word got=%h want=%h", o, e); else n_pass++;
        end
        n_checks += 2;
        if (obs_q.size() != 0) $display("FAIL arst_extra got=%0d want=0", obs_q.size()); else n_pass++;
        if (pd_count - pd0 != 1) $display("FAIL arst_pair_done got=%0d want=1", pd_count - pd0); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_single_pair();
        test_round_robin();
        test_overrun();
        test_timeout();
        test_enable();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
